// File: rtl/mix_columns_pkg.sv
// Shared types and GF(2^8) helpers for the MixColumns engine.
// The inverse constants are only consumed when MIX_COLUMNS_INV_EN is defined.
package mix_columns_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] GF_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction

  // Constants decomposed into sums of powers of two: 09=8+1, 0B=8+2+1, 0D=8+4+1, 0E=8+4+2.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] x, input logic [7:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      8'h02:   return x2;
      8'h03:   return x2 ^ x;
      8'h09:   return x8 ^ x;
      8'h0B:   return x8 ^ x2 ^ x;
      8'h0D:   return x8 ^ x4 ^ x;
      8'h0E:   return x8 ^ x4 ^ x2;
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns on one 32-bit column (row r in byte r).
// Inverse datapath exists only when MIX_COLUMNS_INV_EN is defined.
module mix_column_word
  import mix_columns_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [7:0] b [4];

  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int R1 = (r + 1) % 4;
    localparam int R2 = (r + 2) % 4;
    localparam int R3 = (r + 3) % 4;
    logic [7:0] fwd;

    assign b[r] = col_in[8*r +: 8];
    assign fwd  = gf_mul_const(b[r], 8'h02) ^ gf_mul_const(b[R1], 8'h03) ^ b[R2] ^ b[R3];

`ifdef MIX_COLUMNS_INV_EN
    logic [7:0] bwd;
    assign bwd = gf_mul_const(b[r], 8'h0E) ^ gf_mul_const(b[R1], 8'h0B) ^
                 gf_mul_const(b[R2], 8'h0D) ^ gf_mul_const(b[R3], 8'h09);
    assign col_out[8*r +: 8] = inv ? bwd : fwd;
`else
    assign col_out[8*r +: 8] = fwd;
`endif
  end

`ifndef MIX_COLUMNS_INV_EN
  logic unused_inv;
  assign unused_inv = inv;
`endif

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns engine: COLS_PER_CYCLE columns transformed in place per clock.
// Define MIX_COLUMNS_INV_EN to build the InvMixColumns path and honour in_inv.
module mix_columns_engine
  import mix_columns_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int STATE_W        = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
);

  localparam int         GROUPS   = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_GRP = 2'(GROUPS - 1);

  if (STATE_W != 128) begin : g_bad_state_w
    $error("mix_columns_engine: STATE_W must be 128");
  end
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         cnt;
  logic [STATE_W-1:0] work;
  logic [STATE_W-1:0] work_nxt;
  logic               op_inv;
  logic               accept;
  logic               last_grp;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_grp  = (cnt == LAST_GRP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (last_grp) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic [1:0]  col_sel [COLS_PER_CYCLE];
  logic [31:0] col_in  [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];

  // Group g covers columns g*COLS_PER_CYCLE .. g*COLS_PER_CYCLE+COLS_PER_CYCLE-1.
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign col_sel[k] = 2'(int'(cnt) * COLS_PER_CYCLE + k);
    assign col_in[k]  = work[{col_sel[k], 5'd0} +: 32];

    mix_column_word u_word (
      .col_in  (col_in[k]),
      .inv     (op_inv),
      .col_out (col_out[k])
    );
  end

  always_comb begin
    work_nxt = work;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      work_nxt[{col_sel[k], 5'd0} +: 32] = col_out[k];
    end
  end

`ifdef MIX_COLUMNS_INV_EN
  logic work_inv;
  assign op_inv = work_inv;
`else
  logic unused_in_inv;
  assign op_inv        = 1'b0;
  assign unused_in_inv = in_inv;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 2'd0;
      work     <= '0;
      out_data <= '0;
`ifdef MIX_COLUMNS_INV_EN
      work_inv <= 1'b0;
`endif
    end else if (accept) begin
      cnt  <= 2'd0;
      work <= in_data;
`ifdef MIX_COLUMNS_INV_EN
      work_inv <= in_inv;
`endif
    end else if (state == BUSY) begin
      work <= work_nxt;
      if (last_grp) begin
        cnt      <= 2'd0;
        out_data <= work_nxt;
      end else begin
        cnt <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: one-column and four-column instances share stimulus
// and are checked against a polynomial-arithmetic MixColumns reference.
module tb_mix_columns_engine;

`ifdef MIX_COLUMNS_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_inv = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready1, out_valid1, in_ready4, out_valid4;
  logic [127:0] out_data1, out_data4;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mix_columns_engine #(.COLS_PER_CYCLE(1), .STATE_W(128)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1)
  );

  mix_columns_engine #(.COLS_PER_CYCLE(4), .STATE_W(128)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4)
  );

  // Carry-less product followed by polynomial reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   b [4];
    logic [7:0]   acc;
    logic [127:0] r;
    r = '0;
    if (inv && INV_EN) coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    else               coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) b[rr] = s[32*c + 8*rr +: 8];
      for (int rr = 0; rr < 4; rr++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(b[(rr + j) % 4], coef[j]);
        r[32*c + 8*rr +: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge; offers a state and returns just after the handshake edge.
  task automatic start(input logic [127:0] d, input logic inv, input logic retire);
    in_data   = d;
    in_inv    = inv;
    in_valid  = 1'b1;
    out_ready = retire;
    #1;
    check("in_ready1_offer", 128'(in_ready1), 128'(1));
    check("in_ready4_offer", 128'(in_ready4), 128'(1));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic collect(input logic [127:0] exp, input int hold);
    @(negedge clk);
    check("ov1_t0", 128'(out_valid1), 128'(0));
    check("ov4_t0", 128'(out_valid4), 128'(0));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("ov4_t%0d", k), 128'(out_valid4), 128'(1));
      check($sformatf("ov1_t%0d", k), 128'(out_valid1), 128'(k == 4));
      check($sformatf("data4_t%0d", k), out_data4, exp);
      if (k == 4) check("data1", out_data1, exp);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check($sformatf("hold_ov1_%0d", h), 128'(out_valid1), 128'(1));
      check($sformatf("hold_ov4_%0d", h), 128'(out_valid4), 128'(1));
      check($sformatf("hold_data1_%0d", h), out_data1, exp);
      check($sformatf("hold_data4_%0d", h), out_data4, exp);
      check($sformatf("hold_rdy1_%0d", h), 128'(in_ready1), 128'(0));
      check($sformatf("hold_rdy4_%0d", h), 128'(in_ready4), 128'(0));
    end
  endtask

  task automatic retire(input logic [127:0] exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("ret_ov1", 128'(out_valid1), 128'(0));
    check("ret_ov4", 128'(out_valid4), 128'(0));
    check("ret_rdy1", 128'(in_ready1), 128'(1));
    check("ret_rdy4", 128'(in_ready4), 128'(1));
    check("ret_data1_held", out_data1, exp);
    check("ret_data4_held", out_data4, exp);
  endtask

  initial begin
    logic [127:0] d, e, f;
    logic         inv;

    repeat (2) @(negedge clk);
    check("rst_ov1", 128'(out_valid1), 128'(0));
    check("rst_ov4", 128'(out_valid4), 128'(0));
    check("rst_rdy1", 128'(in_ready1), 128'(1));
    check("rst_rdy4", 128'(in_ready4), 128'(1));
    check("rst_data1", out_data1, 128'(0));
    check("rst_data4", out_data4, 128'(0));

    // Handshake on the very first rising edge after release.
    rst_n = 1'b1;
    d = {4{32'h455313DB}};
    start(d, 1'b0, 1'b0);
    collect({4{32'hBCA14D8E}}, 0);
    retire({4{32'hBCA14D8E}});

    d = {32'hD5D4D4D4, 32'hC6C6C6C6, 32'h01010101, 32'h5C220AF2};
    start(d, 1'b0, 1'b0);
    collect(ref_mix(d, 1'b0), 0);
    check("col0_lit", 128'(out_data4[31:0]), 128'(32'h9D58DC9F));
    check("col1_lit", 128'(out_data4[63:32]), 128'(32'h01010101));
    check("col2_lit", 128'(out_data4[95:64]), 128'(32'hC6C6C6C6));
    retire(ref_mix(d, 1'b0));

    // Inverse request; without the inverse build the forward result is expected.
    d = {4{32'hBCA14D8E}};
    e = INV_EN ? {4{32'h455313DB}} : ref_mix(d, 1'b0);
    start(d, 1'b1, 1'b0);
    collect(e, 0);
    retire(e);

    for (int i = 0; i < 4; i++) begin
      d   = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      e   = ref_mix(d, inv);
      start(d, inv, 1'b0);
      collect(e, 0);
      retire(e);
    end

    for (int i = 0; i < 2; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      f = ref_mix(d, 1'b0);
      start(d, 1'b0, 1'b0);
      collect(f, 0);
      retire(f);
      e = INV_EN ? d : ref_mix(f, 1'b0);
      start(f, 1'b1, 1'b0);
      collect(e, 0);
      retire(e);
    end

    // Back-pressure for five cycles, then retire and accept in the same edge.
    d = {$urandom, $urandom, $urandom, $urandom};
    e = ref_mix(d, 1'b0);
    start(d, 1'b0, 1'b0);
    collect(e, 5);
    d = {$urandom, $urandom, $urandom, $urandom};
    e = ref_mix(d, 1'b1);
    start(d, 1'b1, 1'b1);
    collect(e, 0);
    retire(e);

    // Reset while the one-column instance is mid-transform.
    d = {$urandom, $urandom, $urandom, $urandom};
    start(d, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov1", 128'(out_valid1), 128'(0));
    check("mid_rst_ov4", 128'(out_valid4), 128'(0));
    check("mid_rst_data1", out_data1, 128'(0));
    check("mid_rst_data4", out_data4, 128'(0));
    check("mid_rst_rdy1", 128'(in_ready1), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_ov1_%0d", k), 128'(out_valid1), 128'(0));
      check($sformatf("post_rst_data1_%0d", k), out_data1, 128'(0));
      check($sformatf("post_rst_rdy1_%0d", k), 128'(in_ready1), 128'(1));
    end

    d = {$urandom, $urandom, $urandom, $urandom};
    e = ref_mix(d, 1'b0);
    start(d, 1'b0, 1'b0);
    collect(e, 0);
    retire(e);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
